// File: rtl/pipe_hazard_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_pkg
//   Shared types and constants for the TinyRV hazard unit.
//   stg_idx_t  : stage index (0 = register file, 1 = X, 2 = M, 3 = W, ...)
//   reg_addr_t : architectural register address
//   hz_desc_t  : per-stage in-flight writer descriptor {val, wen, rd, rdy}
//   The HZ_* constants size the shared types; a build that overrides the
//   top-level parameters must change these to match.
// -----------------------------------------------------------------------------
package pipe_hazard_pkg;

  localparam int HZ_NSRC  = 2;
  localparam int HZ_NBACK = 3;
  localparam int HZ_NREG  = 32;
  localparam int HZ_AW    = $clog2(HZ_NREG);
  localparam int HZ_SW    = $clog2(HZ_NBACK + 1);

  typedef logic [HZ_SW-1:0] stg_idx_t;
  typedef logic [HZ_AW-1:0] reg_addr_t;

  // Bypass select value meaning "read the register file".
  localparam stg_idx_t BYP_RF = '0;

  typedef struct packed {
    logic      val;  // stage holds a real instruction
    logic      wen;  // instruction writes the RF
    reg_addr_t rd;   // destination register
    stg_idx_t  rdy;  // first stage whose output carries the result
  } hz_desc_t;

  // True when descriptor d will write register a (x0 writes are ignored).
  function automatic logic desc_writes(hz_desc_t d, reg_addr_t a);
    return d.val & d.wen & (d.rd == a) & (d.rd != '0);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit_if
//   D-stage decode information flowing into the hazard unit and the stage
//   control / bypass selects flowing back out.
//   master : control unit / decoder side (drives decode info, reads controls)
//   slave  : hazard unit side
// -----------------------------------------------------------------------------
interface pipe_hazard_unit_if #(
  parameter int NSRC  = 2,
  parameter int NBACK = 3,
  parameter int NREG  = 32
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(NBACK + 1);

  // decode side
  logic                 val_D;
  logic [NSRC-1:0]      rs_en_D;
  logic [NSRC*AW-1:0]   rs_addr_D;
  logic                 wen_D;
  logic [AW-1:0]        rd_D;
  logic [SW-1:0]        rdy_stg_D;
  logic                 redirect_X;
  logic                 redirect_D;
  logic                 freeze;

  // control side
  logic                 reg_en_F;
  logic                 reg_en_D;
  logic                 squash_F;
  logic [NSRC*SW-1:0]   byp_sel_D;
  logic [NBACK-1:0]     val_stg;
  logic                 rf_wen_W;
  logic [AW-1:0]        rf_waddr_W;

  modport master (
    output val_D, rs_en_D, rs_addr_D, wen_D, rd_D, rdy_stg_D,
           redirect_X, redirect_D, freeze,
    input  reg_en_F, reg_en_D, squash_F, byp_sel_D, val_stg,
           rf_wen_W, rf_waddr_W
  );

  modport slave (
    input  val_D, rs_en_D, rs_addr_D, wen_D, rd_D, rdy_stg_D,
           redirect_X, redirect_D, freeze,
    output reg_en_F, reg_en_D, squash_F, byp_sel_D, val_stg,
           rf_wen_W, rf_waddr_W
  );
endinterface

// File: rtl/pipe_hazard_stage.sv
// -----------------------------------------------------------------------------
// pipe_hazard_stage
//   One in-flight writer descriptor register.
//   clk    : clock
//   rst    : synchronous active-high clear (wins over en)
//   en_i   : advance enable (low while the pipeline is frozen)
//   desc_i : descriptor arriving from the previous stage
//   desc_o : descriptor held by this stage
// -----------------------------------------------------------------------------
module pipe_hazard_stage
  import pipe_hazard_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en_i,
  input  hz_desc_t desc_i,
  output hz_desc_t desc_o
);

  hz_desc_t desc_q;

  // NOTE: non-blocking assignment so every stage samples its predecessor's
  // old value on the same edge; blocking here would collapse the shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only val/wen must be cleared for correctness, but clearing the
      // whole descriptor keeps rd/rdy free of X after reset at no real cost.
      desc_q <= '0;
    end else if (en_i) begin
      desc_q <= desc_i;
    end
  end

  assign desc_o = desc_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
//   Bypass / stall / squash controller for the in-order TinyRV pipeline.
//   Tracks register writers in stages X..W, picks a bypass source for each
//   D-stage operand, stalls D on late results, squashes F on redirects and
//   holds everything on freeze.
//   clk : clock
//   rst : synchronous active-high reset
//   hz  : slave side of pipe_hazard_unit_if (decode info in, controls out)
// -----------------------------------------------------------------------------
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int NSRC  = HZ_NSRC,
  parameter int NBACK = HZ_NBACK,
  parameter int NREG  = HZ_NREG
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_unit_if.slave   hz
);

  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(NBACK + 1);

  hz_desc_t           stg_d [1:NBACK];
  hz_desc_t           stg_q [1:NBACK];
  logic               advance;
  logic               hazard_any;
  logic               stall_D;
  logic [NSRC*SW-1:0] byp_flat;
  logic [NBACK-1:0]   val_flat;

  assign advance = ~hz.freeze;

  // A stalled or redirect-killed D instruction enters X as a bubble.
  always_comb begin
    stg_d[1] = '{val: hz.val_D & ~stall_D & ~hz.redirect_X,
                 wen: hz.wen_D,
                 rd:  hz.rd_D,
                 rdy: hz.rdy_stg_D};
    for (int k = 2; k <= NBACK; k++) begin
      stg_d[k] = stg_q[k-1];
    end
  end

  for (genvar k = 1; k <= NBACK; k++) begin : g_stg
    pipe_hazard_stage u_stg (
      .clk    (clk),
      .rst    (rst),
      .en_i   (advance),
      .desc_i (stg_d[k]),
      .desc_o (stg_q[k])
    );
  end

  // Per-operand priority match. Stages are scanned oldest to youngest so the
  // youngest matching writer is the one left in sel/haz at the end.
  always_comb begin : p_match
    reg_addr_t addr;
    stg_idx_t  sel;
    logic      haz;
    // NOTE: every variable gets a value before any conditional path, so no
    // latch is inferred for the don't-match case.
    hazard_any = 1'b0;
    byp_flat   = '0;
    addr       = '0;
    sel        = BYP_RF;
    haz        = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      addr = hz.rs_addr_D[i*AW +: AW];
      sel  = BYP_RF;
      haz  = 1'b0;
      if (hz.val_D && hz.rs_en_D[i]) begin
        for (int k = NBACK; k >= 1; k--) begin
          if (desc_writes(stg_q[k], addr)) begin
            sel = stg_idx_t'(k);
            // Result not produced yet while the writer sits before its rdy stage.
            haz = (stg_idx_t'(k) < stg_q[k].rdy);
          end
        end
      end
      byp_flat[i*SW +: SW] = sel;
      hazard_any           = hazard_any | haz;
    end
  end

  // A redirect in X kills D anyway, so it never waits on a hazard.
  assign stall_D = hazard_any & ~hz.redirect_X;

  always_comb begin
    val_flat = '0;
    for (int k = 1; k <= NBACK; k++) begin
      val_flat[k-1] = stg_q[k].val;
    end
  end

  assign hz.byp_sel_D  = byp_flat;
  assign hz.reg_en_F   = ~(stall_D | hz.freeze);
  assign hz.reg_en_D   = ~(stall_D | hz.freeze);
  assign hz.squash_F   = (hz.redirect_X | hz.redirect_D) & ~hz.freeze;
  assign hz.val_stg    = val_flat;
  assign hz.rf_wen_W   = stg_q[NBACK].val & stg_q[NBACK].wen;
  assign hz.rf_waddr_W = stg_q[NBACK].rd;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_unit
//   Self-checking bench: a list-of-in-flight-instructions model predicts the
//   hazard unit's outputs every cycle; directed scenarios add hand-computed
//   literal expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_unit;

  localparam int NSRC  = 2;
  localparam int NBACK = 3;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int SW    = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.NSRC(NSRC), .NBACK(NBACK), .NREG(NREG)) hif ();

  pipe_hazard_unit #(.NSRC(NSRC), .NBACK(NBACK), .NREG(NREG)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: a list of the real instructions past D, each with its current stage.
  // ---------------------------------------------------------------------------
  typedef struct {
    int rd;
    bit w;
    int rdy;
    int stg;
  } op_t;

  op_t ops[$];
  int  exp_sel [NSRC];
  bit  exp_stall;

  function automatic void model_eval();
    bit h;
    h = 0;
    for (int i = 0; i < NSRC; i++) begin
      int best, brdy, a;
      best = 0;
      brdy = 0;
      a    = int'(hif.rs_addr_D[i*AW +: AW]);
      if (hif.val_D && hif.rs_en_D[i] && a != 0) begin
        foreach (ops[j]) begin
          if (ops[j].w && ops[j].rd == a && (best == 0 || ops[j].stg < best)) begin
            best = ops[j].stg;
            brdy = ops[j].rdy;
          end
        end
      end
      exp_sel[i] = best;
      if (best != 0 && best < brdy) h = 1;
    end
    exp_stall = h && !hif.redirect_X;
  endfunction

  task automatic compare_model();
    bit [NBACK-1:0] ev;
    bit             ew;
    int             ea;
    if (rst) return;
    model_eval();
    check("reg_en_F", hif.reg_en_F, !(exp_stall || hif.freeze));
    check("reg_en_D", hif.reg_en_D, !(exp_stall || hif.freeze));
    check("squash_F", hif.squash_F, (hif.redirect_X || hif.redirect_D) && !hif.freeze);
    if (!exp_stall) begin
      for (int i = 0; i < NSRC; i++)
        check($sformatf("byp_sel[%0d]", i), 32'(hif.byp_sel_D[i*SW +: SW]), exp_sel[i]);
    end
    ev = '0;
    ew = 0;
    ea = 0;
    foreach (ops[j]) begin
      ev[ops[j].stg-1] = 1'b1;
      if (ops[j].stg == NBACK && ops[j].w) begin
        ew = 1;
        ea = ops[j].rd;
      end
    end
    check("val_stg", 32'(hif.val_stg), 32'(ev));
    check("rf_wen_W", hif.rf_wen_W, ew);
    if (ew) check("rf_waddr_W", 32'(hif.rf_waddr_W), ea);
  endtask

  task automatic model_update();
    op_t nxt[$];
    if (rst) begin
      ops.delete();
      return;
    end
    if (hif.freeze) return;
    model_eval();
    foreach (ops[j]) begin
      op_t o;
      o = ops[j];
      o.stg++;
      if (o.stg <= NBACK) nxt.push_back(o);
    end
    if (hif.val_D && !exp_stall && !hif.redirect_X)
      nxt.push_back('{rd: int'(hif.rd_D), w: hif.wen_D, rdy: int'(hif.rdy_stg_D), stg: 1});
    ops = nxt;
  endtask

  // Apply inputs (just after a rising edge) and let them settle.
  task automatic drive(input bit v, input bit [1:0] en, input int a0, input int a1,
                       input bit w, input int rd, input int rdy,
                       input bit rx, input bit rdd, input bit frz);
    hif.val_D      = v;
    hif.rs_en_D    = en;
    hif.rs_addr_D  = {AW'(a1), AW'(a0)};
    hif.wen_D      = w;
    hif.rd_D       = AW'(rd);
    hif.rdy_stg_D  = SW'(rdy);
    hif.redirect_X = rx;
    hif.redirect_D = rdd;
    hif.freeze     = frz;
    #1;
  endtask

  // Compare against the model, take one clock edge, advance the model.
  task automatic step();
    compare_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    drive(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic flush();
    repeat (NBACK) begin
      idle();
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    repeat (2) step();
    rst = 1'b0;

    // Reset state
    idle();
    check("rst_val_stg", 32'(hif.val_stg), 0);
    check("rst_rf_wen", hif.rf_wen_W, 0);
    check("rst_reg_en_F", hif.reg_en_F, 1);
    check("rst_byp_sel", 32'(hif.byp_sel_D), 0);
    step();

    // ALU chain: add x5 (rdy=1) then add x6,x5,x5
    drive(1, 2'b00, 0, 0, 1, 5, 1, 0, 0, 0);
    step();
    drive(1, 2'b11, 5, 5, 1, 6, 1, 0, 0, 0);
    check("alu_byp_sel", 32'(hif.byp_sel_D), 32'h5);
    check("alu_no_stall", hif.reg_en_D, 1);
    step();
    flush();

    // Load-use: lw x7 (rdy=2) then add x8,x7,x0
    drive(1, 2'b00, 0, 0, 1, 7, 2, 0, 0, 0);
    step();
    drive(1, 2'b11, 7, 0, 1, 8, 1, 0, 0, 0);
    check("lu_stall", hif.reg_en_D, 0);
    step();
    drive(1, 2'b11, 7, 0, 1, 8, 1, 0, 0, 0);
    check("lu_released", hif.reg_en_D, 1);
    check("lu_sel0", 32'(hif.byp_sel_D[SW-1:0]), 2);
    check("lu_sel1", 32'(hif.byp_sel_D[2*SW-1:SW]), 0);
    check("lu_bubble", 32'(hif.val_stg), 32'b010);
    step();
    flush();

    // Priority: x3 writers in W and M; D reads x3
    drive(1, 2'b00, 0, 0, 1, 3, 1, 0, 0, 0);
    step();
    drive(1, 2'b00, 0, 0, 1, 3, 1, 0, 0, 0);
    step();
    idle();
    step();
    drive(1, 2'b01, 3, 0, 0, 0, 1, 0, 0, 0);
    check("prio_sel", 32'(hif.byp_sel_D[SW-1:0]), 2);
    step();
    flush();

    // x0 writer in X never bypasses
    drive(1, 2'b00, 0, 0, 1, 0, 3, 0, 0, 0);
    step();
    drive(1, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0);
    check("x0_sel", 32'(hif.byp_sel_D[SW-1:0]), 0);
    check("x0_no_stall", hif.reg_en_D, 1);
    step();
    flush();

    // Redirect in X during a load-use stall
    drive(1, 2'b00, 0, 0, 1, 7, 2, 0, 0, 0);
    step();
    drive(1, 2'b01, 7, 0, 1, 8, 1, 1, 0, 0);
    check("redir_squash", hif.squash_F, 1);
    check("redir_reg_en_D", hif.reg_en_D, 1);
    step();
    idle();
    check("redir_bubble", 32'(hif.val_stg), 32'b010);
    step();
    flush();

    // Freeze 3 cycles with lw in X and an x4 writer in W
    drive(1, 2'b00, 0, 0, 1, 4, 1, 0, 0, 0);
    step();
    idle();
    step();
    drive(1, 2'b00, 0, 0, 1, 9, 2, 0, 0, 0);
    step();
    for (int c = 0; c < 3; c++) begin
      drive(1, 2'b01, 9, 0, 1, 10, 1, 1, 0, 1);
      check("frz_val_stg", 32'(hif.val_stg), 32'b101);
      check("frz_rf_wen", hif.rf_wen_W, 1);
      check("frz_waddr", 32'(hif.rf_waddr_W), 4);
      check("frz_reg_en_F", hif.reg_en_F, 0);
      check("frz_squash", hif.squash_F, 0);
      step();
    end
    idle();
    check("frz_held", 32'(hif.val_stg), 32'b101);
    step();
    idle();
    check("frz_resume", 32'(hif.val_stg), 32'b010);
    check("frz_resume_wen", hif.rf_wen_W, 0);
    step();
    flush();

    // Reset mid-operation while frozen discards descriptors
    drive(1, 2'b00, 0, 0, 1, 11, 3, 0, 0, 0);
    step();
    rst = 1'b1;
    drive(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1);
    step();
    rst = 1'b0;
    idle();
    check("rst_frz_clear", 32'(hif.val_stg), 0);
    step();

    // Randomized run
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 9) < 8,
            2'($urandom_range(0, 3)),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 3),
            $urandom_range(1, 3),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
